// File: rtl/rl02_defs.sv
// Shared RL02 deframer definitions: FSM state encoding and the serial CRC-16 step.
package rl02_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HUNT  = 2'd1,
        ST_FIELD = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'h0000;

    // One MSB-first step of the x^16+x^15+x^2+1 register.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc_in, input logic bit_in);
        return {crc_in[14:0], 1'b0} ^ ((crc_in[15] ^ bit_in) ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/mfm_crc16.sv
// Serial CRC-16 register, advanced by one bit per qualified strobe.
module mfm_crc16
    import rl02_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        bitIn,
    input  logic        bitValid,
    output logic [15:0] crc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= CRC16_INIT;
        end else if (clear) begin
            crc <= CRC16_INIT;
        end else if (bitValid) begin
            crc <= crc16_step(crc, bitIn);
        end
    end

endmodule

// File: rtl/mfm_field_deframer.sv
// Hunts a zero preamble plus sync bit in the decoded RL02 stream, assembles
// fieldLen 16-bit words MSB-first and verifies the trailing CRC-16 word.
module mfm_field_deframer
    import rl02_defs::*;
#(
    parameter int PREAMBLE_MIN = 32,
    parameter int TIMEOUT      = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        currentRealBit,
    input  logic        currentRealBitValid,
    input  logic        arm,
    input  logic        abort,
    input  logic [7:0]  fieldLen,
    output logic        busy,
    output logic        synced,
    output logic [15:0] wordOut,
    output logic        wordValid,
    output logic        done,
    output logic        crcOk,
    output logic        lostSync
);

    localparam int ZW = $clog2(PREAMBLE_MIN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [ZW-1:0] PRE_MAX = ZW'(PREAMBLE_MIN);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    state_t        state;
    logic [ZW-1:0] zero_cnt;
    logic [3:0]    bit_cnt;
    logic [7:0]    word_cnt;
    logic [7:0]    field_len;
    logic [TW-1:0] tmo_cnt;
    logic [15:0]   shift_reg;
    logic [15:0]   shift_next;
    logic [15:0]   crc;
    logic [15:0]   crc_next;
    logic          timed_out;
    logic          arm_ok;
    logic          crc_en;

    assign timed_out  = (state != ST_IDLE) && (tmo_cnt == TMO_MAX);
    assign arm_ok     = (state == ST_IDLE) && !busy && arm && !abort;
    // The sync bit is consumed in HUNT, so only FIELD/CHECK bits reach the CRC.
    assign crc_en     = currentRealBitValid && !abort && !timed_out &&
                        ((state == ST_FIELD) || (state == ST_CHECK));
    assign shift_next = {shift_reg[14:0], currentRealBit};
    assign crc_next   = crc16_step(crc, currentRealBit);

    mfm_crc16 u_crc (
        .clk      (clk),
        .rst      (rst),
        .clear    (arm_ok),
        .bitIn    (currentRealBit),
        .bitValid (crc_en),
        .crc      (crc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            zero_cnt  <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            field_len <= '0;
            tmo_cnt   <= '0;
            shift_reg <= '0;
            busy      <= 1'b0;
            synced    <= 1'b0;
            wordOut   <= '0;
            wordValid <= 1'b0;
            done      <= 1'b0;
            crcOk     <= 1'b0;
            lostSync  <= 1'b0;
        end else begin
            wordValid <= 1'b0;
            done      <= 1'b0;
            if (abort) begin
                state  <= ST_IDLE;
                busy   <= 1'b0;
                synced <= 1'b0;
            end else if (timed_out) begin
                // A strobe coinciding with expiry is dropped; busy stays up through the done cycle.
                lostSync <= 1'b1;
                crcOk    <= 1'b0;
                done     <= 1'b1;
                synced   <= 1'b0;
                state    <= ST_IDLE;
            end else begin
                if (state != ST_IDLE) begin
                    tmo_cnt <= currentRealBitValid ? '0 : tmo_cnt + TW'(1);
                end
                case (state)
                    ST_IDLE: begin
                        if (busy) begin
                            busy <= 1'b0;
                        end else if (arm) begin
                            field_len <= fieldLen;
                            zero_cnt  <= '0;
                            bit_cnt   <= '0;
                            word_cnt  <= '0;
                            tmo_cnt   <= '0;
                            crcOk     <= 1'b0;
                            lostSync  <= 1'b0;
                            busy      <= 1'b1;
                            state     <= ST_HUNT;
                        end
                    end
                    ST_HUNT: begin
                        if (currentRealBitValid) begin
                            if (!currentRealBit) begin
                                if (zero_cnt != PRE_MAX) zero_cnt <= zero_cnt + ZW'(1);
                            end else if (zero_cnt == PRE_MAX) begin
                                synced <= 1'b1;
                                state  <= (field_len == 8'd0) ? ST_CHECK : ST_FIELD;
                            end else begin
                                zero_cnt <= '0;
                            end
                        end
                    end
                    ST_FIELD: begin
                        if (currentRealBitValid) begin
                            shift_reg <= shift_next;
                            bit_cnt   <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'hF) begin
                                wordOut   <= shift_next;
                                wordValid <= 1'b1;
                                word_cnt  <= word_cnt + 8'd1;
                                if (word_cnt + 8'd1 == field_len) state <= ST_CHECK;
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (currentRealBitValid) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'hF) begin
                                crcOk  <= (crc_next == 16'h0000);
                                done   <= 1'b1;
                                synced <= 1'b0;
                                state  <= ST_IDLE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
